// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_ctrl
// Description : Memory-mapped N-digit 7-segment display controller with
//               multiplexed scanning, hex-to-segment decode and per-slot PWM
//               brightness. Common-cathode digit enables, active-high
//               segments.
// Ports       : CLK      - system clock
//               RST      - synchronous active-high reset
//               address  - register select (ADDR_W bits)
//               dataIn   - 16-bit write data
//               load     - write strobe, sampled on rising CLK
//               dataOut  - combinational read of register[address]
//               seg      - segments A..G (seg[0]=A), active-high, registered
//               DP       - decimal point, active-high, registered
//               CC       - digit commons, active-low, CC[0] = LS digit
// Register map: 0..N-1 digit {blank, hex[3:0]}, N DP bits, N+1 ctrl
//               {EN[8], BRIGHT[3:0]}, N+2 blink mask, others unmapped.
// Config      : define SEG_DISPLAY_BLINK_EN to build the blink counter and
//               the blink mask register; otherwise the mask address is
//               unmapped.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 3,
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_DIV  = 4194304
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_W-1:0]     address,
    input  logic [15:0]           dataIn,
    input  logic                  load,
    output logic [15:0]           dataOut,
    output logic [6:0]            seg,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] CC
);

    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [ADDR_W-1:0]  c_ADDR_DP   = ADDR_W'(NUM_DIGITS);
    localparam logic [ADDR_W-1:0]  c_ADDR_CTRL = ADDR_W'(NUM_DIGITS + 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_MASK = ADDR_W'(NUM_DIGITS + 2);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || (1 << ADDR_W) < NUM_DIGITS + 3 ||
        SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_param_check
        $error("seg_display_ctrl: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // CPU-side register file
    // ------------------------------------------------------------------
    logic [4:0]            r_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_dp;
    logic [3:0]            r_bright;
    logic                  r_en;

    logic                  w_addr_is_digit;
    logic [c_IDX_W-1:0]    w_addr_idx;

    assign w_addr_is_digit = (address < c_ADDR_DP);
    assign w_addr_idx      = address[c_IDX_W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= 5'h10;
            end
            r_dp     <= '0;
            r_bright <= 4'hF;
            r_en     <= 1'b1;
        end else if (load) begin
            if (w_addr_is_digit) begin
                r_digit[w_addr_idx] <= dataIn[4:0];
            end
            if (address == c_ADDR_DP) begin
                r_dp <= dataIn[NUM_DIGITS-1:0];
            end
            if (address == c_ADDR_CTRL) begin
                r_bright <= dataIn[3:0];
                r_en     <= dataIn[8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan counters: prescaler -> PWM phase -> digit index
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_pre;
    logic [3:0]         r_phase;
    logic [c_IDX_W-1:0] r_idx;
    logic               w_pre_wrap;

    assign w_pre_wrap = (r_pre == c_PRE_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pre   <= '0;
            r_phase <= 4'd0;
            r_idx   <= '0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + c_PRE_W'(1);
            if (w_pre_wrap) begin
                r_phase <= r_phase + 4'd1;
                if (r_phase == 4'd15) begin
                    r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional blink logic
    // ------------------------------------------------------------------
    logic                  w_blink_dark;
    logic [NUM_DIGITS-1:0] w_mask_rd;

`ifdef SEG_DISPLAY_BLINK_EN
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);

    logic [c_BLK_W-1:0]    r_blink_cnt;
    logic                  r_blink_phase;
    logic [NUM_DIGITS-1:0] r_mask;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_mask        <= '0;
        end else begin
            if (load && (address == c_ADDR_MASK)) begin
                r_mask <= dataIn[NUM_DIGITS-1:0];
            end
            if (r_blink_cnt == c_BLK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
            end
        end
    end

    assign w_blink_dark = r_blink_phase & r_mask[r_idx];
    assign w_mask_rd    = r_mask;
`else
    assign w_blink_dark = 1'b0;
    assign w_mask_rd    = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        dataOut = 16'h0000;
        if (w_addr_is_digit) begin
            dataOut = {11'd0, r_digit[w_addr_idx]};
        end else if (address == c_ADDR_DP) begin
            dataOut = 16'(r_dp);
        end else if (address == c_ADDR_CTRL) begin
            dataOut = {7'd0, r_en, 4'd0, r_bright};
        end else if (address == c_ADDR_MASK) begin
            dataOut = 16'(w_mask_rd);
        end
    end

    // ------------------------------------------------------------------
    // Segment decode and registered display outputs
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [4:0]            w_cur;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_cur    = r_digit[r_idx];
    // Phase 15 can never be below a 4-bit BRIGHT, which guarantees one dark
    // phase at the end of every slot to hide ghosting between digits.
    assign w_lit    = r_en & (r_phase < r_bright) & ~w_cur[4] & ~w_blink_dark;
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            seg <= 7'd0;
            DP  <= 1'b0;
            CC  <= '1;
        end else if (w_lit) begin
            seg <= hex_to_seg(w_cur[3:0]);
            DP  <= r_dp[r_idx];
            CC  <= ~w_onehot;
        end else begin
            seg <= 7'd0;
            DP  <= 1'b0;
            CC  <= '1;
        end
    end

    // Not every data bit maps to a register field.
    logic w_unused_data;
    assign w_unused_data = ^dataIn;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_ctrl
// Description : Directed self-checking bench for seg_display_ctrl with
//               NUM_DIGITS=4, ADDR_W=3, SCAN_DIV=2, BLINK_DIV=64. One slot is
//               32 clocks, one full scan 128 clocks. The bench counts clock
//               edges since reset (k); display outputs sampled after edge k
//               reflect scan state k-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [2:0]  address = 3'd0;
    logic [15:0] dataIn  = 16'h0000;
    logic        load    = 1'b0;
    logic [15:0] dataOut;
    logic [6:0]  seg;
    logic        DP;
    logic [3:0]  CC;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_display_ctrl #(
        .NUM_DIGITS (4),
        .ADDR_W     (3),
        .SCAN_DIV   (2),
        .BLINK_DIV  (64)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .address (address),
        .dataIn  (dataIn),
        .load    (load),
        .dataOut (dataOut),
        .seg     (seg),
        .DP      (DP),
        .CC      (CC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        address = 3'(a);
        dataIn  = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] want [8] = '{16'h0010, 16'h0010, 16'h0010, 16'h0010,
                                  16'h0000, 16'h010F, 16'h0000, 16'h0000};
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({CC, seg, DP} !== {4'b1111, 7'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got CC=%b seg=%h DP=%b want CC=1111 seg=00 DP=0", CC, seg, DP);
        end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            total++;
            if (dataOut !== want[a]) begin
                bad++;
                $display("FAIL reset_read addr=%0d got %h want %h", a, dataOut, want[a]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_regs();
        logic [15:0] want [8] = '{16'h0010, 16'h0010, 16'h0010, 16'h0010,
                                  16'h0000, 16'h010F, 16'h0000, 16'h0000};
        // Unused data bits read back as zero.
        wr(0, 16'hFFFF);
        address = 3'd0; #1;
        total++;
        if (dataOut !== 16'h001F) begin
            bad++;
            $display("FAIL digit_mask got %h want 001F", dataOut);
        end
        wr(4, 16'hFFFF);
        address = 3'd4; #1;
        total++;
        if (dataOut !== 16'h000F) begin
            bad++;
            $display("FAIL dp_mask got %h want 000F", dataOut);
        end
        wr(4, 16'h0000);
        wr(0, 16'h0010);
        // Same-cycle write and read: old value until the edge.
        address = 3'd1; dataIn = 16'h0007; load = 1'b1;
        #1;
        total++;
        if (dataOut !== 16'h0010) begin
            bad++;
            $display("FAIL read_before_edge got %h want 0010", dataOut);
        end
        tick();
        load = 1'b0;
        total++;
        if (dataOut !== 16'h0007) begin
            bad++;
            $display("FAIL read_after_edge got %h want 0007", dataOut);
        end
        wr(1, 16'h0010);
        // Unmapped address: write ignored, nothing else disturbed.
        wr(7, 16'hFFFF);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            total++;
            if (dataOut !== want[a]) begin
                bad++;
                $display("FAIL unmapped_write addr=%0d got %h want %h", a, dataOut, want[a]);
            end
        end
    endtask

    task automatic test_single_digit();
        int s, idx, ph;
        logic lit;
        logic [3:0] ecc;
        logic [6:0] eseg;
        wr(0, 16'h0003);
        wr(4, 16'h0001);
        repeat (2) tick();
        for (int n = 0; n < 128; n++) begin
            tick();
            s = k - 1; idx = (s / 32) % 4; ph = (s / 2) % 16;
            lit  = (idx == 0) && (ph < 15);
            ecc  = lit ? 4'b1110 : 4'b1111;
            eseg = lit ? 7'h4F : 7'h00;
            total++;
            if ({CC, seg, DP} !== {ecc, eseg, lit}) begin
                bad++;
                $display("FAIL single_digit k=%0d got CC=%b seg=%h DP=%b want CC=%b seg=%h DP=%b",
                         k, CC, seg, DP, ecc, eseg, lit);
            end
        end
    endtask

    task automatic test_decode();
        logic found;
        wr(4, 16'h0000);
        for (int h = 0; h < 16; h++) begin
            wr(0, 16'(h));
            repeat (2) tick();
            found = 1'b0;
            for (int w = 0; w < 200 && !found; w++) begin
                if (((k - 1) % 128) == 2) found = 1'b1;
                else tick();
            end
            total++;
            if (!found) begin
                bad++;
                $display("FAIL decode_timeout hex=%0d got no slot 0 want slot 0 within 200 clocks", h);
            end else if ({CC, seg, DP} !== {4'b1110, tbl[h], 1'b0}) begin
                bad++;
                $display("FAIL decode hex=%0d got CC=%b seg=%h DP=%b want CC=1110 seg=%h DP=0",
                         h, CC, seg, DP, tbl[h]);
            end
        end
    endtask

    task automatic test_brightness();
        int s, idx, ph;
        int lows [4];
        logic lit;
        logic [3:0] one = 4'b0001;
        logic [3:0] ecc;
        wr(5, 16'h0104);
        for (int i = 0; i < 4; i++) wr(i, 16'h0008);
        wr(4, 16'h0000);
        repeat (2) tick();
        for (int b = 0; b < 4; b++) lows[b] = 0;
        for (int n = 0; n < 128; n++) begin
            tick();
            s = k - 1; idx = (s / 32) % 4; ph = (s / 2) % 16;
            lit = (ph < 4);
            ecc = lit ? ~(one << idx) : 4'b1111;
            for (int b = 0; b < 4; b++) if (CC[b] == 1'b0) lows[b]++;
            total++;
            if ({CC, seg, DP} !== {ecc, (lit ? 7'h7F : 7'h00), 1'b0}) begin
                bad++;
                $display("FAIL bright4 k=%0d got CC=%b seg=%h want CC=%b", k, CC, seg, ecc);
            end
        end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (lows[b] !== 8) begin
                bad++;
                $display("FAIL bright4_duty digit=%0d got %0d active clocks want 8", b, lows[b]);
            end
        end
        // BRIGHT=0: permanently dark.
        wr(5, 16'h0100);
        repeat (2) tick();
        for (int n = 0; n < 128; n++) begin
            tick();
            total++;
            if ({CC, seg, DP} !== {4'b1111, 7'h00, 1'b0}) begin
                bad++;
                $display("FAIL bright0 k=%0d got CC=%b seg=%h DP=%b want CC=1111 seg=00 DP=0", k, CC, seg, DP);
            end
        end
        // EN=0 with full brightness: dark.
        wr(5, 16'h000F);
        repeat (2) tick();
        for (int n = 0; n < 128; n++) begin
            tick();
            total++;
            if ({CC, seg, DP} !== {4'b1111, 7'h00, 1'b0}) begin
                bad++;
                $display("FAIL enable_off k=%0d got CC=%b seg=%h DP=%b want CC=1111 seg=00 DP=0", k, CC, seg, DP);
            end
        end
        // Re-enable: scan position must have kept advancing while disabled.
        wr(5, 16'h010F);
        repeat (2) tick();
        for (int n = 0; n < 128; n++) begin
            tick();
            s = k - 1; idx = (s / 32) % 4; ph = (s / 2) % 16;
            lit = (ph < 15);
            ecc = lit ? ~(one << idx) : 4'b1111;
            total++;
            if ({CC, seg} !== {ecc, (lit ? 7'h7F : 7'h00)}) begin
                bad++;
                $display("FAIL enable_on k=%0d got CC=%b seg=%h want CC=%b", k, CC, seg, ecc);
            end
        end
    endtask

    task automatic test_blink();
        int s, idx, ph, bph;
        logic lit;
        logic [3:0] one = 4'b0001;
        logic [3:0] ecc;
        wr(6, 16'h0001);
        address = 3'd6; #1;
        total++;
`ifdef SEG_DISPLAY_BLINK_EN
        if (dataOut !== 16'h0001) begin
            bad++;
            $display("FAIL mask_read got %h want 0001", dataOut);
        end
`else
        if (dataOut !== 16'h0000) begin
            bad++;
            $display("FAIL mask_read got %h want 0000", dataOut);
        end
`endif
        repeat (2) tick();
        for (int n = 0; n < 256; n++) begin
            tick();
            s = k - 1; idx = (s / 32) % 4; ph = (s / 2) % 16; bph = (s / 64) % 2;
            lit = (ph < 15);
`ifdef SEG_DISPLAY_BLINK_EN
            if (idx == 0 && bph == 1) lit = 1'b0;
`endif
            ecc = lit ? ~(one << idx) : 4'b1111;
            total++;
            if ({CC, seg, DP} !== {ecc, (lit ? 7'h7F : 7'h00), 1'b0}) begin
                bad++;
                $display("FAIL blink k=%0d got CC=%b seg=%h want CC=%b", k, CC, seg, ecc);
            end
        end
        wr(6, 16'h0000);
    endtask

    task automatic test_reset_midscan();
        int s, idx, ph;
        logic lit;
        logic found;
        logic [15:0] want [8] = '{16'h0010, 16'h0010, 16'h0010, 16'h0010,
                                  16'h0000, 16'h010F, 16'h0000, 16'h0000};
        found = 1'b0;
        for (int w = 0; w < 300 && !found; w++) begin
            if ((k % 128) == 78) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL midscan_timeout got no slot 2 phase 7 want it within 300 clocks");
        end else if (CC !== 4'b1011) begin
            bad++;
            $display("FAIL midscan_pre got CC=%b want 1011", CC);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({CC, seg, DP} !== {4'b1111, 7'h00, 1'b0}) begin
            bad++;
            $display("FAIL midscan_dark got CC=%b seg=%h DP=%b want CC=1111 seg=00 DP=0", CC, seg, DP);
        end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            total++;
            if (dataOut !== want[a]) begin
                bad++;
                $display("FAIL midscan_regs addr=%0d got %h want %h", a, dataOut, want[a]);
            end
        end
        rst = 1'b0;
        // Only digit 0 visible; scan must have restarted from digit 0.
        wr(0, 16'h0008);
        repeat (2) tick();
        for (int n = 0; n < 128; n++) begin
            tick();
            s = k - 1; idx = (s / 32) % 4; ph = (s / 2) % 16;
            lit = (idx == 0) && (ph < 15);
            total++;
            if ({CC, seg, DP} !== {(lit ? 4'b1110 : 4'b1111), (lit ? 7'h7F : 7'h00), 1'b0}) begin
                bad++;
                $display("FAIL midscan_restart k=%0d got CC=%b seg=%h want lit=%b", k, CC, seg, lit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_single_digit();
        test_decode();
        test_brightness();
        test_blink();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
